// File: rtl/goertzel_pkg.sv
// Shared types and constants for the Goertzel measurement sequencer and its sample counter.
package goertzel_pkg;

  localparam int NF_DEF  = 12;
  localparam int FW_DEF  = 32;
  localparam int CW_DEF  = 32;
  localparam int NSW_DEF = 32;

  // Bit positions of the sequencer flags inside the SPI status register.
  localparam int STATUS_CORDIC_MSK = 0;
  localparam int STATUS_HERZEL_MSK = 1;

  typedef enum logic [2:0] {
    IDLE,
    COEF_REQ,
    COEF_WR,
    CLEAR,
    ACCUM,
    FINAL,
    WAIT
  } state_t;

endpackage

// File: rtl/goertzel_smp_ctr.sv
// Saturating sample counter: counts accepted samples up to limit and flags the step that reaches it.
module goertzel_smp_ctr #(
  parameter int NSW = goertzel_pkg::NSW_DEF
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           inc,
  input  logic [NSW-1:0] limit,
  output logic [NSW-1:0] cnt,
  output logic           last
);

  // High during the increment that makes cnt equal to limit.
  assign last = inc && (cnt == limit - NSW'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + NSW'(1);
    end
  end

endmodule

// File: rtl/goertzel_seq.sv
// Measurement sequencer: loads all bin coefficients through the shared CORDIC, gates
// num_samp samples into the bin bank, issues the final step and collects per-bin valids.
module goertzel_seq
  import goertzel_pkg::*;
#(
  parameter int NF  = NF_DEF,
  parameter int FW  = FW_DEF,
  parameter int CW  = CW_DEF,
  parameter int NSW = NSW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NF*FW-1:0]      freq,
  input  logic [FW-1:0]         samp_freq,
  input  logic [NSW-1:0]        num_samp,
  output logic                  cordic_req,
  output logic [FW-1:0]         cordic_freq,
  output logic [FW-1:0]         cordic_fs,
  input  logic                  cordic_ack,
  input  logic [CW-1:0]         cordic_coef,
  output logic                  coef_we,
  output logic [$clog2(NF)-1:0] coef_idx,
  output logic [CW-1:0]         coef_data,
  input  logic                  smp_valid,
  output logic                  bank_clear,
  output logic                  smp_step,
  output logic                  bank_final,
  input  logic [NF-1:0]         bank_valid,
  output logic                  stat_coef,
  output logic                  stat_done,
  output logic                  stat_err,
  output logic [NSW-1:0]        smp_cnt,
  output state_t                state
);

  localparam int IW = $clog2(NF);

  logic [IW-1:0] idx;
  logic [NF-1:0] bv_q;
  logic [NF-1:0] seen;
  logic [FW-1:0] freq_arr [NF];
  logic          last_step;
  logic          ctr_clr;

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      freq_arr[i] = freq[i*FW +: FW];
    end
  end

  // Steps go to the bank in the same cycle as the sample; abort suppresses them at once.
  assign smp_step = smp_valid && (state == ACCUM) && !abort && !rst;
  assign ctr_clr  = rst || abort || (state == CLEAR);

  goertzel_smp_ctr #(.NSW(NSW)) u_smp_ctr (
    .clk   (clk),
    .clr   (ctr_clr),
    .inc   (smp_step),
    .limit (num_samp),
    .cnt   (smp_cnt),
    .last  (last_step)
  );

  // CORDIC handshake: cordic_req stays high with cordic_freq/cordic_fs stable until the
  // single-cycle cordic_ack; cordic_coef is captured on that cycle and req drops on the same edge.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= IDLE;
      idx         <= '0;
      cordic_req  <= 1'b0;
      cordic_freq <= '0;
      cordic_fs   <= '0;
      coef_we     <= 1'b0;
      coef_idx    <= '0;
      coef_data   <= '0;
      bank_clear  <= 1'b0;
      bank_final  <= 1'b0;
      stat_coef   <= 1'b0;
      stat_done   <= 1'b0;
      stat_err    <= 1'b0;
      bv_q        <= '0;
      seen        <= '0;
    end else begin
      coef_we    <= 1'b0;
      bank_clear <= 1'b0;
      bank_final <= 1'b0;
      bv_q       <= bank_valid;
      case (state)
        IDLE: begin
          if (start) begin
            if ((num_samp != '0) && (samp_freq != '0)) begin
              stat_err    <= 1'b0;
              stat_coef   <= 1'b0;
              stat_done   <= 1'b0;
              idx         <= '0;
              cordic_req  <= 1'b1;
              cordic_freq <= freq_arr[0];
              cordic_fs   <= samp_freq;
              state       <= COEF_REQ;
            end else begin
              stat_err <= 1'b1;
            end
          end
        end
        COEF_REQ: begin
          // Re-entry after a write leaves req low for one idle cycle before reissuing.
          if (!cordic_req) begin
            cordic_req  <= 1'b1;
            cordic_freq <= freq_arr[idx];
            cordic_fs   <= samp_freq;
          end else if (cordic_ack) begin
            cordic_req <= 1'b0;
            coef_we    <= 1'b1;
            coef_idx   <= idx;
            coef_data  <= cordic_coef;
            state      <= COEF_WR;
          end
        end
        COEF_WR: begin
          if (idx == IW'(NF - 1)) begin
            bank_clear <= 1'b1;
            state      <= CLEAR;
          end else begin
            idx   <= idx + 1'b1;
            state <= COEF_REQ;
          end
        end
        CLEAR: begin
          stat_coef <= 1'b1;
          state     <= ACCUM;
        end
        ACCUM: begin
          if (last_step) begin
            bank_final <= 1'b1;
            state      <= FINAL;
          end
        end
        FINAL: begin
          seen  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          seen <= seen | bv_q;
          if (&(seen | bv_q)) begin
            stat_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goertzel_seq.sv
// Directed/randomized bench for goertzel_seq with a CORDIC responder and a coefficient scoreboard.
module tb_goertzel_seq;
  import goertzel_pkg::*;

  localparam int NF  = 12;
  localparam int FW  = 32;
  localparam int CW  = 32;
  localparam int NSW = 32;
  localparam int IW  = $clog2(NF);
  localparam int W   = IW + CW;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic [NF*FW-1:0]  freq;
  logic [FW-1:0]     samp_freq;
  logic [NSW-1:0]    num_samp;
  logic              cordic_req;
  logic [FW-1:0]     cordic_freq, cordic_fs;
  logic              cordic_ack = 1'b0;
  logic [CW-1:0]     cordic_coef = '0;
  logic              coef_we;
  logic [IW-1:0]     coef_idx;
  logic [CW-1:0]     coef_data;
  logic              smp_valid;
  logic              bank_clear, smp_step, bank_final;
  logic [NF-1:0]     bank_valid;
  logic              stat_coef, stat_done, stat_err;
  logic [NSW-1:0]    smp_cnt;
  state_t            dbg_state;

  logic [FW-1:0]     freq_tab [NF];
  logic [W-1:0]      exp_q [$];
  int checks = 0, errors = 0;
  int step_cnt = 0, final_cnt = 0, clear_cnt = 0;
  int ack_cnt = 0;
  logic req_prev = 1'b0;
  int nsamp;

  goertzel_seq #(.NF(NF), .FW(FW), .CW(CW), .NSW(NSW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .freq(freq),
    .samp_freq(samp_freq), .num_samp(num_samp), .cordic_req(cordic_req),
    .cordic_freq(cordic_freq), .cordic_fs(cordic_fs), .cordic_ack(cordic_ack),
    .cordic_coef(cordic_coef), .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_data(coef_data), .smp_valid(smp_valid), .bank_clear(bank_clear),
    .smp_step(smp_step), .bank_final(bank_final), .bank_valid(bank_valid),
    .stat_coef(stat_coef), .stat_done(stat_done), .stat_err(stat_err),
    .smp_cnt(smp_cnt), .state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int out_ones();
    return $countones({cordic_req, cordic_freq, cordic_fs, coef_we, coef_idx, coef_data,
                       bank_clear, smp_step, bank_final, stat_coef, stat_done, stat_err, smp_cnt});
  endfunction

  function automatic int bin_of(input logic [FW-1:0] f);
    for (int i = 0; i < NF; i++) if (freq_tab[i] == f) return i;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic new_freqs();
    for (int i = 0; i < NF; i++) begin
      freq_tab[i] = FW'(i * 1000 + $urandom_range(1, 999));
      freq[i*FW +: FW] = freq_tab[i];
    end
  endtask

  // Reference model: one write per bin in ascending order, data = bin * 0x100.
  task automatic push_coefs();
    for (int i = 0; i < NF; i++) exp_q.push_back({IW'(i), CW'(i * 256)});
  endtask

  task automatic wait_coef(input int budget);
    int n = 0;
    while (!stat_coef && n < budget) begin
      tick();
      n++;
    end
    check("coef_wait", 64'(stat_coef), 64'(1));
  endtask

  // ---------------- CORDIC responder: ack 5 cycles after req rises ----------------
  always @(posedge clk) begin
    #1;
    cordic_ack = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        cordic_ack  = 1'b1;
        cordic_coef = CW'(bin_of(cordic_freq) * 256);
        check("cordic_fs", 64'(cordic_fs), 64'(samp_freq));
      end
    end else if (cordic_req && !req_prev) begin
      ack_cnt = 4;
    end
    req_prev = cordic_req;
  end

  // ---------------- scoreboard / pulse monitors ----------------
  always @(negedge clk) begin
    if (smp_step)   step_cnt++;
    if (bank_final) final_cnt++;
    if (bank_clear) clear_cnt++;
    if (coef_we) begin
      check("coef_pending", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) check("coef_wr", 64'({coef_idx, coef_data}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b1; abort = 1'b0; smp_valid = 1'b0; bank_valid = '0;
    num_samp = '0; samp_freq = '0; freq = '0;

    // Reset with start held high.
    repeat (3) begin
      tick();
      check("rst_outs", 64'(out_ones()), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(IDLE));
    end
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_no_req", 64'(cordic_req), 64'(0));

    // Coefficient load.
    new_freqs();
    samp_freq = FW'($urandom_range(8000, 96000));
    num_samp  = NSW'(5000);
    push_coefs();
    pulse_start();
    check("start_req", 64'(cordic_req), 64'(1));
    check("start_freq", 64'(cordic_freq), 64'(freq_tab[0]));
    check("start_err", 64'(stat_err), 64'(0));
    repeat (83) tick();
    check("coef_pre", 64'(stat_coef), 64'(0));
    check("clear_pulse", 64'(bank_clear), 64'(1));
    tick();
    check("coef_set", 64'(stat_coef), 64'(1));
    check("coef_all", 64'(exp_q.size()), 64'(0));
    check("clear_once", 64'(clear_cnt), 64'(1));
    check("accum_state", 64'(dbg_state), 64'(ACCUM));

    // Accumulate 5000 samples, one every 10 cycles, with a start thrown in mid-way.
    step_cnt = 0;
    for (int n = 1; n <= 5000; n++) begin
      smp_valid = 1'b1;
      if (n == 100) start = 1'b1;
      tick();
      smp_valid = 1'b0;
      start = 1'b0;
      if (n == 100) begin
        check("busy_start_state", 64'(dbg_state), 64'(ACCUM));
        check("busy_start_req", 64'(cordic_req), 64'(0));
      end
      if (n % 1000 == 0 && n < 5000) check("smp_cnt_mid", 64'(smp_cnt), 64'(n));
      if (n < 5000) repeat (9) tick();
    end
    check("final_pulse", 64'(bank_final), 64'(1));
    check("final_state", 64'(dbg_state), 64'(FINAL));
    check("steps_5000", 64'(step_cnt), 64'(5000));
    check("smp_cnt_5000", 64'(smp_cnt), 64'(5000));
    tick();
    check("final_drop", 64'(bank_final), 64'(0));
    check("final_once", 64'(final_cnt), 64'(1));
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
    check("extra_no_step", 64'(step_cnt), 64'(5000));
    check("smp_cnt_sat", 64'(smp_cnt), 64'(5000));

    // Completion: staggered single-cycle valids, bit NF-1 last.
    for (int b = 0; b < NF - 1; b++) begin
      bank_valid = '0;
      bank_valid[b] = 1'b1;
      tick();
      bank_valid = '0;
      repeat ($urandom_range(0, 3)) tick();
    end
    check("done_early", 64'(stat_done), 64'(0));
    check("wait_state", 64'(dbg_state), 64'(WAIT));
    bank_valid = '0;
    bank_valid[NF-1] = 1'b1;
    tick();
    bank_valid = '0;
    check("done_1cyc", 64'(stat_done), 64'(0));
    tick();
    check("done_2cyc", 64'(stat_done), 64'(1));
    check("done_idle", 64'(dbg_state), 64'(IDLE));

    // Rejected starts.
    num_samp = '0;
    pulse_start();
    check("err_nsamp", 64'(stat_err), 64'(1));
    check("err_no_req", 64'(cordic_req), 64'(0));
    check("err_done_held", 64'(stat_done), 64'(1));
    num_samp = NSW'(8);
    samp_freq = '0;
    pulse_start();
    repeat (3) tick();
    check("err_fs", 64'(stat_err), 64'(1));
    check("err_fs_no_req", 64'(cordic_req), 64'(0));

    // Abort in the middle of accumulation.
    samp_freq = FW'($urandom_range(8000, 96000));
    num_samp  = NSW'(3000);
    new_freqs();
    push_coefs();
    pulse_start();
    check("ab_err_clr", 64'(stat_err), 64'(0));
    check("ab_done_clr", 64'(stat_done), 64'(0));
    wait_coef(200);
    step_cnt = 0;
    for (int n = 1; n < 2500; n++) begin
      smp_valid = 1'b1;
      tick();
      smp_valid = 1'b0;
      tick();
    end
    check("ab_cnt", 64'(smp_cnt), 64'(2499));
    abort = 1'b1;
    smp_valid = 1'b1;
    tick();
    check("ab_outs", 64'(out_ones()), 64'(0));
    check("ab_state", 64'(dbg_state), 64'(IDLE));
    abort = 1'b0;
    smp_valid = 1'b0;
    repeat (4) begin
      smp_valid = ~smp_valid;
      tick();
    end
    smp_valid = 1'b0;
    check("ab_no_step", 64'(step_cnt), 64'(2499));
    check("ab_no_final", 64'(final_cnt), 64'(1));

    // Fresh full run after abort.
    nsamp = $urandom_range(20, 60);
    num_samp = NSW'(nsamp);
    new_freqs();
    push_coefs();
    clear_cnt = 0;
    pulse_start();
    wait_coef(200);
    check("re_cnt0", 64'(smp_cnt), 64'(0));
    check("re_coef_all", 64'(exp_q.size()), 64'(0));
    check("re_clear", 64'(clear_cnt), 64'(1));
    step_cnt = 0;
    for (int n = 1; n <= nsamp; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      smp_valid = 1'b1;
      tick();
      smp_valid = 1'b0;
      if (n == nsamp / 2) check("re_cnt_mid", 64'(smp_cnt), 64'(n));
    end
    check("re_final", 64'(bank_final), 64'(1));
    check("re_cnt_end", 64'(smp_cnt), 64'(nsamp));
    check("re_steps", 64'(step_cnt), 64'(nsamp));
    tick();
    bank_valid = '1;
    tick();
    bank_valid = '0;
    tick();
    check("re_done", 64'(stat_done), 64'(1));
    check("re_idle", 64'(dbg_state), 64'(IDLE));
    check("re_final_cnt", 64'(final_cnt), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
